// File: rtl/wb_arbiter2_if.sv
// Wishbone point-to-point link used on every side of the arbiter.
// The master modport belongs to whoever initiates cycles; the slave modport answers them.
interface wb_arbiter2_if #(
  parameter int AW = 26,
  parameter int DW = 32
);
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic          we;
  logic          stb;
  logic          cyc;
  logic          tagn;
  logic          ack;
  logic          err;

  modport master (output adr, dat_w, we, stb, cyc, tagn, input dat_r, ack);
  modport slave  (input adr, dat_w, we, stb, cyc, tagn, output dat_r, ack, err);
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter in front of one slave, with a stalled-strobe
// watchdog that aborts the owner's cycle and flags it with a one-cycle err pulse.
module wb_arbiter2 #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  wb_arbiter2_if.slave        m0,
  wb_arbiter2_if.slave        m1,
  wb_arbiter2_if.master       s,
  output logic [1:0]          gnt_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT0  = 2'd1;
  localparam logic [1:0] GNT1  = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;
  localparam logic [7:0] WDOG_MAX = 8'(TIMEOUT - 1);

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       r_last;
  logic       r_owner;
  logic [7:0] r_wdog;
  logic       w_own0;
  logic       w_own1;
  logic       w_stall;
  logic       w_timeout;

  assign w_own0    = (r_state == GNT0);
  assign w_own1    = (r_state == GNT1);
  assign w_stall   = (w_own0 | w_own1) & s.stb & ~s.ack;
  // An ack on the final count rescues the transfer; only a still-stalled strobe aborts.
  assign w_timeout = w_stall & (r_wdog == WDOG_MAX);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0.cyc && m1.cyc) w_next = r_last ? GNT0 : GNT1;
        else if (m0.cyc)      w_next = GNT0;
        else if (m1.cyc)      w_next = GNT1;
      end
      GNT0: begin
        if (w_timeout)    w_next = ABORT;
        else if (!m0.cyc) w_next = m1.cyc ? GNT1 : IDLE;
      end
      GNT1: begin
        if (w_timeout)    w_next = ABORT;
        else if (!m1.cyc) w_next = m0.cyc ? GNT0 : IDLE;
      end
      ABORT: begin
        if (!(r_owner ? m1.cyc : m0.cyc)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_wdog  <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wdog <= 8'd0;
        if (w_next == GNT0) begin
          r_last  <= 1'b0;
          r_owner <= 1'b0;
        end else if (w_next == GNT1) begin
          r_last  <= 1'b1;
          r_owner <= 1'b1;
        end
      end else if (w_stall) begin
        r_wdog <= r_wdog + 8'd1;
      end else begin
        r_wdog <= 8'd0;
      end
    end
  end

  // Idle and abort park the slave bus at all-zero rather than leaving it floating.
  always_comb begin
    s.adr   = '0;
    s.dat_w = '0;
    s.we    = 1'b0;
    s.stb   = 1'b0;
    s.cyc   = 1'b0;
    s.tagn  = 1'b0;
    if (w_own0) begin
      s.adr   = m0.adr;
      s.dat_w = m0.dat_w;
      s.we    = m0.we;
      s.stb   = m0.stb;
      s.cyc   = m0.cyc;
      s.tagn  = m0.tagn;
    end else if (w_own1) begin
      s.adr   = m1.adr;
      s.dat_w = m1.dat_w;
      s.we    = m1.we;
      s.stb   = m1.stb;
      s.cyc   = m1.cyc;
      s.tagn  = m1.tagn;
    end
  end

  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = w_own0 & s.ack;
  assign m1.ack   = w_own1 & s.ack;
  assign m0.err   = w_own0 & w_timeout;
  assign m1.err   = w_own1 & w_timeout;
  assign gnt_o    = {w_own1, w_own0};

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench: stimulus pushes expected ack/err responses into a queue, and an
// independent monitor pops and checks them whenever a master sees ack or err.
module tb_wb_arbiter2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;

  always #5 clk = ~clk;

  wb_arbiter2_if #(.AW(26), .DW(32)) m0_if ();
  wb_arbiter2_if #(.AW(26), .DW(32)) m1_if ();
  wb_arbiter2_if #(.AW(26), .DW(32)) s_if ();

  wb_arbiter2 #(.AW(26), .DW(32), .TIMEOUT(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .gnt_o (gnt)
  );

  typedef struct {
    logic [3:0]  code;   // {m1_err, m0_err, m1_ack, m0_ack}
    logic [1:0]  gnt;
    logic [31:0] dat;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input logic [3:0] c, input logic [1:0] g, input logic [31:0] d);
    exp_t e;
    e.code = c;
    e.gnt  = g;
    e.dat  = d;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any ack/err seen by a master must match the next queued expectation.
  initial begin
    logic [3:0] code;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) continue;
      code = {m1_if.err, m0_if.err, m1_if.ack, m0_if.ack};
      if (code != 4'b0000) begin
        if (q.size() == 0) begin
          chk("unexpected_resp", 64'(code), 64'd0);
        end else begin
          e = q.pop_front();
          chk("resp_who", 64'(code), 64'(e.code));
          chk("resp_gnt", 64'(gnt), 64'(e.gnt));
          if (e.code[0]) chk("resp_dat_m0", 64'(m0_if.dat_r), 64'(e.dat));
          if (e.code[1]) chk("resp_dat_m1", 64'(m1_if.dat_r), 64'(e.dat));
        end
      end
    end
  end

  initial begin
    int early;
    rst = 1'b1;
    m0_if.adr = '0; m0_if.dat_w = '0; m0_if.we = 0; m0_if.stb = 0; m0_if.cyc = 0; m0_if.tagn = 0;
    m1_if.adr = '0; m1_if.dat_w = '0; m1_if.we = 0; m1_if.stb = 0; m1_if.cyc = 0; m1_if.tagn = 0;
    s_if.dat_r = 32'h1234_5678; s_if.ack = 0; s_if.err = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_sbus", 64'({s_if.cyc, s_if.stb, s_if.we, s_if.tagn, s_if.adr}), 64'd0);
    chk("rst_resp", 64'({m1_if.err, m0_if.err, m1_if.ack, m0_if.ack}), 64'd0);
    chk("rst_dat_m0", 64'(m0_if.dat_r), 64'h1234_5678);
    chk("rst_dat_m1", 64'(m1_if.dat_r), 64'h1234_5678);
    @(posedge clk); #1;
    rst = 1'b0;

    // Simultaneous requests, three rounds: m0, m1, m0, m1, m0, m1
    m0_if.adr = 26'h10; m0_if.cyc = 1; m0_if.stb = 1;
    m1_if.adr = 26'h20; m1_if.cyc = 1; m1_if.stb = 1;
    for (int r = 0; r < 3; r++) begin
      tick();
      if (r > 0) begin m1_if.cyc = 1; m1_if.stb = 1; end
      s_if.ack = 1; s_if.dat_r = 32'hA000_0000 + 32'(r);
      push(4'b0001, 2'b01, 32'hA000_0000 + 32'(r));
      @(negedge clk); chk("rr_adr_m0", 64'(s_if.adr), 64'h10);
      tick();
      s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
      @(negedge clk); chk("rr_hold_m0", 64'(gnt), 64'd1);
      tick();
      if (r < 2) begin m0_if.cyc = 1; m0_if.stb = 1; end
      s_if.ack = 1; s_if.dat_r = 32'hB000_0000 + 32'(r);
      push(4'b0010, 2'b10, 32'hB000_0000 + 32'(r));
      @(negedge clk); chk("rr_adr_m1", 64'(s_if.adr), 64'h20);
      tick();
      s_if.ack = 0; m1_if.cyc = 0; m1_if.stb = 0;
      @(negedge clk); chk("rr_hold_m1", 64'(gnt), 64'd2);
    end
    tick();
    @(negedge clk); chk("rr_idle", 64'(gnt), 64'd0);

    // Single master read, ack in the second granted cycle
    m0_if.adr = 26'h100; m0_if.we = 0; m0_if.cyc = 1; m0_if.stb = 1;
    tick();
    @(negedge clk);
    chk("single_gnt", 64'(gnt), 64'd1);
    chk("single_adr", 64'(s_if.adr), 64'h100);
    chk("single_scyc", 64'({s_if.cyc, s_if.stb}), 64'd3);
    tick();
    s_if.ack = 1; s_if.dat_r = 32'hDEAD_BEEF;
    push(4'b0001, 2'b01, 32'hDEAD_BEEF);
    tick();
    s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
    tick();

    // Burst hold: m1 4-beat write while m0 waits
    m1_if.adr = 26'h40; m1_if.we = 1; m1_if.cyc = 1; m1_if.stb = 1; m1_if.dat_w = 32'h1;
    tick();
    m0_if.adr = 26'h80; m0_if.cyc = 1; m0_if.stb = 1;
    s_if.dat_r = 32'h0;
    for (int b = 1; b <= 4; b++) begin
      m1_if.dat_w = 32'(b); s_if.ack = 1;
      push(4'b0010, 2'b10, 32'h0);
      @(negedge clk);
      chk("burst_dat", 64'(s_if.dat_w), 64'(b));
      chk("burst_we", 64'(s_if.we), 64'd1);
      tick();
    end
    s_if.ack = 0; m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0;
    @(negedge clk); chk("burst_hold_gnt", 64'(gnt), 64'd2);
    tick();
    @(negedge clk);
    chk("burst_handover_gnt", 64'(gnt), 64'd1);
    chk("burst_handover_adr", 64'(s_if.adr), 64'h80);
    m0_if.cyc = 0; m0_if.stb = 0;
    tick();

    // Timeout: slave never acks; err exactly 15 cycles after grant
    m0_if.adr = 26'h200; m0_if.cyc = 1; m0_if.stb = 1;
    push(4'b0100, 2'b01, 32'h0);
    tick();
    early = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (m0_if.err !== 1'b0 || s_if.cyc !== 1'b1) early++;
      tick();
    end
    chk("to_no_early_err", 64'(early), 64'd0);
    @(negedge clk);
    chk("to_err_pulse", 64'(m0_if.err), 64'd1);
    tick();
    s_if.ack = 1;
    @(negedge clk);
    chk("to_abort_scyc", 64'({s_if.cyc, s_if.stb, s_if.adr}), 64'd0);
    chk("to_late_ack", 64'({m0_if.ack, m0_if.err}), 64'd0);
    chk("to_abort_gnt", 64'(gnt), 64'd0);
    tick();
    s_if.ack = 0; m0_if.cyc = 0; m0_if.stb = 0;
    tick();
    m0_if.cyc = 1; m0_if.stb = 1;
    @(negedge clk); chk("to_idle_after", 64'(s_if.cyc), 64'd0);
    tick();
    @(negedge clk); chk("to_regrant", 64'(gnt), 64'd1);
    m0_if.cyc = 0; m0_if.stb = 0;
    tick();

    // Asynchronous reset mid-transfer, then a tie goes to m0
    m1_if.adr = 26'h300; m1_if.dat_w = 32'h55; m1_if.we = 1; m1_if.cyc = 1; m1_if.stb = 1;
    tick();
    @(negedge clk); chk("arst_pre_gnt", 64'(gnt), 64'd2);
    #2 rst = 1'b1;
    m0_if.cyc = 1; m0_if.stb = 1;
    #1;
    chk("arst_scyc_stb", 64'({s_if.cyc, s_if.stb}), 64'd0);
    chk("arst_gnt", 64'(gnt), 64'd0);
    chk("arst_resp", 64'({m1_if.err, m0_if.err, m1_if.ack, m0_if.ack}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    @(negedge clk); chk("arst_tie_m0", 64'(gnt), 64'd1);
    m0_if.cyc = 0; m0_if.stb = 0; m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0;
    tick();

    // Idle outputs with junk on unrequesting masters
    m0_if.adr = 26'h3FF_FFFF; m0_if.dat_w = 32'hFFFF_FFFF; m0_if.we = 1;
    m1_if.adr = 26'h2AA_AAAA; m1_if.dat_w = 32'hAAAA_AAAA; m1_if.we = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", 64'({s_if.adr, s_if.dat_w, s_if.we, gnt}), 64'd0);
      tick();
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
